// File: rtl/usb_fs_nb_out_pe_ext_if.sv
// rtl/usb_fs_nb_out_pe_ext_if.sv - rx/tx/endpoint-side signal bundle of the OUT protocol engine
interface usb_fs_nb_out_pe_ext_if #(
  parameter int NumOutEps         = 2,
  parameter int MaxOutPktSizeByte = 64
);
  localparam int PktW = $clog2(MaxOutPktSizeByte);

  logic                 link_reset_i;
  logic [6:0]           dev_addr_i;
  logic [NumOutEps-1:0] out_ep_enabled_i;
  logic [NumOutEps-1:0] out_ep_full_i;
  logic [NumOutEps-1:0] out_ep_stall_i;
  logic [NumOutEps-1:0] out_ep_iso_i;
  logic [NumOutEps-1:0] data_toggle_clear_i;
  logic                 rx_pkt_start_i;
  logic                 rx_pkt_end_i;
  logic                 rx_pkt_valid_i;
  logic [3:0]           rx_pid_i;
  logic [6:0]           rx_addr_i;
  logic [3:0]           rx_endp_i;
  logic                 rx_data_put_i;
  logic [7:0]           rx_data_i;
  logic                 tx_pkt_start_o;
  logic [3:0]           tx_pid_o;
  logic [3:0]           out_ep_current_o;
  logic                 out_ep_data_put_o;
  logic [PktW-1:0]      out_ep_put_addr_o;
  logic [7:0]           out_ep_data_o;
  logic                 out_ep_newpkt_o;
  logic                 out_ep_acked_o;
  logic                 out_ep_rollback_o;
  logic [NumOutEps-1:0] out_ep_setup_o;
  logic [PktW:0]        out_ep_byte_cnt_o;
  logic                 out_ep_timeout_o;
  logic                 out_ep_babble_o;

  modport master (
    output link_reset_i, dev_addr_i, out_ep_enabled_i, out_ep_full_i, out_ep_stall_i,
           out_ep_iso_i, data_toggle_clear_i, rx_pkt_start_i, rx_pkt_end_i, rx_pkt_valid_i,
           rx_pid_i, rx_addr_i, rx_endp_i, rx_data_put_i, rx_data_i,
    input  tx_pkt_start_o, tx_pid_o, out_ep_current_o, out_ep_data_put_o, out_ep_put_addr_o,
           out_ep_data_o, out_ep_newpkt_o, out_ep_acked_o, out_ep_rollback_o, out_ep_setup_o,
           out_ep_byte_cnt_o, out_ep_timeout_o, out_ep_babble_o
  );

  modport slave (
    input  link_reset_i, dev_addr_i, out_ep_enabled_i, out_ep_full_i, out_ep_stall_i,
           out_ep_iso_i, data_toggle_clear_i, rx_pkt_start_i, rx_pkt_end_i, rx_pkt_valid_i,
           rx_pid_i, rx_addr_i, rx_endp_i, rx_data_put_i, rx_data_i,
    output tx_pkt_start_o, tx_pid_o, out_ep_current_o, out_ep_data_put_o, out_ep_put_addr_o,
           out_ep_data_o, out_ep_newpkt_o, out_ep_acked_o, out_ep_rollback_o, out_ep_setup_o,
           out_ep_byte_cnt_o, out_ep_timeout_o, out_ep_babble_o
  );
endinterface

// File: rtl/usb_fs_nb_out_pe_ext.sv
// rtl/usb_fs_nb_out_pe_ext.sv - full-speed USB OUT/SETUP protocol engine
// Adds turnaround timeout, babble detection and byte-count reporting to the non-buffered engine.
module usb_fs_nb_out_pe_ext #(
  parameter int NumOutEps         = 2,
  parameter int MaxOutPktSizeByte = 64,
  parameter int TimeoutCycles     = 864
) (
  input logic                   clk_48mhz_i,
  input logic                   rst_i,
  usb_fs_nb_out_pe_ext_if.slave bus
);
  localparam int PktW = $clog2(MaxOutPktSizeByte);
  localparam int TmoW = $clog2(TimeoutCycles);
  localparam logic [PktW:0]   MaxCnt  = (PktW+1)'(MaxOutPktSizeByte);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

  localparam logic [3:0] PidOut   = 4'b0001;
  localparam logic [3:0] PidSetup = 4'b1101;
  localparam logic [3:0] PidData0 = 4'b0011;
  localparam logic [3:0] PidData1 = 4'b1011;
  localparam logic [3:0] PidAck   = 4'b0010;
  localparam logic [3:0] PidNak   = 4'b1010;
  localparam logic [3:0] PidStall = 4'b1110;

  typedef enum logic [2:0] {
    Idle, RcvdOut, RcvdDataStart, RcvdDataEnd, RcvdIsoDataEnd
  } state_e;

  state_e               state;
  logic [NumOutEps-1:0] toggle;
  logic                 setup_q, nak_q, babble_q;
  logic [PktW:0]        cnt;
  logic [TmoW-1:0]      tmo;

  // Zero-extended per-endpoint vectors so a 4-bit endpoint number can index them safely.
  logic [15:0] en16, full16, stall16, iso16, tog16;
  logic [3:0]  cur;
  logic        token_ok, out_or_setup, data_end, mismatch, cnt_full, addr_max;

  assign en16    = 16'(bus.out_ep_enabled_i);
  assign full16  = 16'(bus.out_ep_full_i);
  assign stall16 = 16'(bus.out_ep_stall_i);
  assign iso16   = 16'(bus.out_ep_iso_i);
  assign tog16   = 16'(toggle);
  assign cur     = bus.out_ep_current_o;

  assign token_ok = bus.rx_pkt_end_i && bus.rx_pkt_valid_i && (bus.rx_pid_i[1:0] == 2'b01) &&
                    (bus.rx_addr_i == bus.dev_addr_i) && (32'(bus.rx_endp_i) < NumOutEps) &&
                    en16[bus.rx_endp_i];
  assign out_or_setup = (bus.rx_pid_i == PidOut) || (bus.rx_pid_i == PidSetup);
  assign data_end = bus.rx_pkt_end_i && bus.rx_pkt_valid_i &&
                    ((bus.rx_pid_i == PidData0) || (bus.rx_pid_i == PidData1));
  assign mismatch = bus.rx_pid_i[3] != tog16[cur];
  assign cnt_full = cnt == MaxCnt;
  assign addr_max = &bus.out_ep_put_addr_o;

  always_ff @(posedge clk_48mhz_i) begin
    if (rst_i || bus.link_reset_i) begin
      state                 <= Idle;
      toggle                <= '0;
      setup_q               <= 1'b0;
      nak_q                 <= 1'b0;
      babble_q              <= 1'b0;
      cnt                   <= '0;
      tmo                   <= '0;
      bus.tx_pkt_start_o    <= 1'b0;
      bus.tx_pid_o          <= '0;
      bus.out_ep_current_o  <= '0;
      bus.out_ep_data_put_o <= 1'b0;
      bus.out_ep_put_addr_o <= '0;
      bus.out_ep_data_o     <= '0;
      bus.out_ep_newpkt_o   <= 1'b0;
      bus.out_ep_acked_o    <= 1'b0;
      bus.out_ep_rollback_o <= 1'b0;
      bus.out_ep_byte_cnt_o <= '0;
      bus.out_ep_timeout_o  <= 1'b0;
      bus.out_ep_babble_o   <= 1'b0;
      if (rst_i) bus.out_ep_setup_o <= '0;
    end else begin
      bus.tx_pkt_start_o    <= 1'b0;
      bus.out_ep_newpkt_o   <= 1'b0;
      bus.out_ep_acked_o    <= 1'b0;
      bus.out_ep_rollback_o <= 1'b0;
      bus.out_ep_timeout_o  <= 1'b0;
      bus.out_ep_babble_o   <= 1'b0;
      bus.out_ep_data_put_o <= 1'b0;
      bus.out_ep_data_o     <= bus.rx_data_i;

      if (bus.out_ep_data_put_o && full16[cur]) nak_q <= 1'b1;
      // Once NAKed the buffer keeps overwriting the same slot; rollback discards it anyway.
      if (bus.out_ep_data_put_o && !nak_q && !addr_max)
        bus.out_ep_put_addr_o <= bus.out_ep_put_addr_o + 1'b1;

      case (state)
        Idle: begin
          nak_q <= 1'b0;
          tmo   <= '0;
          if (token_ok && out_or_setup) begin
            state                <= RcvdOut;
            bus.out_ep_newpkt_o  <= 1'b1;
            bus.out_ep_current_o <= bus.rx_endp_i;
            setup_q              <= bus.rx_pid_i == PidSetup;
            for (int i = 0; i < NumOutEps; i++) begin
              if (bus.rx_endp_i == 4'(i)) begin
                bus.out_ep_setup_o[i] <= bus.rx_pid_i == PidSetup;
                if (bus.rx_pid_i == PidSetup) toggle[i] <= 1'b0;
              end
            end
          end
        end

        RcvdOut: begin
          nak_q                 <= 1'b0;
          babble_q              <= 1'b0;
          cnt                   <= '0;
          bus.out_ep_put_addr_o <= '0;
          if (bus.rx_pkt_start_i) begin
            state <= RcvdDataStart;
            tmo   <= '0;
          end else if (tmo == TmoLast) begin
            state                <= Idle;
            bus.out_ep_timeout_o <= 1'b1;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end

        RcvdDataStart: begin
          if (bus.rx_data_put_i) begin
            if (cnt_full) begin
              babble_q <= 1'b1;
            end else begin
              bus.out_ep_data_put_o <= 1'b1;
              cnt                   <= cnt + 1'b1;
            end
          end
          if (bus.rx_pkt_end_i) begin
            if (iso16[cur] && data_end) begin
              state <= RcvdIsoDataEnd;
            end else if (data_end && mismatch) begin
              // Host missed our last ACK and is retrying: re-ACK, keep the toggle.
              state                 <= Idle;
              bus.out_ep_rollback_o <= 1'b1;
              bus.tx_pkt_start_o    <= 1'b1;
              bus.tx_pid_o          <= PidAck;
            end else if (!data_end) begin
              state                 <= Idle;
              bus.out_ep_rollback_o <= 1'b1;
            end else if (babble_q) begin
              state                 <= Idle;
              bus.out_ep_rollback_o <= 1'b1;
              bus.out_ep_babble_o   <= 1'b1;
            end else begin
              state <= RcvdDataEnd;
            end
          end
        end

        RcvdDataEnd: begin
          state              <= Idle;
          bus.tx_pkt_start_o <= 1'b1;
          if (stall16[cur] && !setup_q) begin
            bus.tx_pid_o <= PidStall;
          end else if (nak_q) begin
            bus.tx_pid_o          <= PidNak;
            bus.out_ep_rollback_o <= 1'b1;
          end else begin
            bus.tx_pid_o          <= PidAck;
            bus.out_ep_acked_o    <= 1'b1;
            bus.out_ep_byte_cnt_o <= cnt;
            for (int i = 0; i < NumOutEps; i++)
              if (cur == 4'(i)) toggle[i] <= ~toggle[i];
          end
        end

        RcvdIsoDataEnd: begin
          state <= Idle;
          if (stall16[cur] && !setup_q) begin
            bus.tx_pkt_start_o <= 1'b1;
            bus.tx_pid_o       <= PidStall;
          end else if (nak_q) begin
            bus.out_ep_rollback_o <= 1'b1;
          end else begin
            bus.out_ep_acked_o    <= 1'b1;
            bus.out_ep_byte_cnt_o <= cnt;
            for (int i = 0; i < NumOutEps; i++)
              if (cur == 4'(i)) toggle[i] <= ~toggle[i];
          end
        end

        default: state <= Idle;
      endcase

      // Software clear wins over any toggle update made above in the same cycle.
      for (int i = 0; i < NumOutEps; i++)
        if (bus.data_toggle_clear_i[i]) toggle[i] <= 1'b0;
    end
  end
endmodule
